// File: rtl/fir_stream_engine.sv
// Purpose : streaming FIR filter (pTAP_NUM taps, one MAC per cycle) with bypass mode and run control.
// Latency : FIR output valid in the 12th cycle after input handshake (pTAP_NUM+1); bypass in the 1st.
// Backpressure: one sample in flight; input stalls (ss_tready=0) until the output has been accepted.
module fir_stream_engine #(
    parameter int pDATA_WIDTH = 32,
    parameter int pTAP_NUM    = 11,
    parameter int pTAP_AW     = 5
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   cfg_we,
    input  logic [pTAP_AW-1:0]     cfg_addr,
    input  logic [pDATA_WIDTH-1:0] cfg_wdata,
    input  logic                   cfg_mode,
    input  logic [4:0]             cfg_shift,
    input  logic                   ap_start,
    input  logic [15:0]            data_length,
    output logic                   ap_idle,
    output logic                   ap_done,
    input  logic                   ss_tvalid,
    output logic                   ss_tready,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast
);

    localparam int ACC_W = 2*pDATA_WIDTH + 5;
    localparam logic [pTAP_AW-1:0] LAST_IDX = pTAP_AW'(pTAP_NUM - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WAIT_IN, S_MAC, S_OUT, S_DONE} state_t;

    state_t                   state_q;
    logic [pDATA_WIDTH-1:0]   tap_q  [pTAP_NUM];
    logic [pDATA_WIDTH-1:0]   hist_q [pTAP_NUM];
    logic [pTAP_AW-1:0]       wptr_q, rptr_q, idx_q;
    logic [ACC_W-1:0]         acc_q;
    logic [15:0]              cnt_q, len_q;
    logic                     mode_q, last_q;
    logic [4:0]               shift_q;
    logic                     ap_idle_q, ap_done_q, ss_tready_q, sm_tvalid_q, sm_tlast_q;
    logic [pDATA_WIDTH-1:0]   sm_tdata_q;

    logic signed [2*pDATA_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]         acc_d, shifted;
    logic [pTAP_AW-1:0]              wptr_d, rptr_d;
    logic                            last_d;

    // Next-state datapath: one signed MAC step, output shift, circular pointer stepping.
    always_comb begin
        prod    = $signed(tap_q[idx_q]) * $signed(hist_q[rptr_q]);
        acc_d   = $signed(acc_q) + ACC_W'(prod);
        shifted = acc_d >>> shift_q;
        wptr_d  = (wptr_q == LAST_IDX) ? '0 : wptr_q + 1'b1;
        rptr_d  = (rptr_q == '0) ? LAST_IDX : rptr_q - 1'b1;
        last_d  = ss_tlast || ((cnt_q + 16'd1) == len_q);
    end

    // Control FSM with registered outputs, tap/history storage and accumulator.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            mode_q      <= 1'b0;
            last_q      <= 1'b0;
            shift_q     <= '0;
            ap_idle_q   <= 1'b1;
            ap_done_q   <= 1'b0;
            ss_tready_q <= 1'b0;
            sm_tvalid_q <= 1'b0;
            sm_tlast_q  <= 1'b0;
            sm_tdata_q  <= '0;
            for (int i = 0; i < pTAP_NUM; i++) begin
                tap_q[i]  <= '0;
                hist_q[i] <= '0;
            end
        end else begin
            // Taps are only writable between runs; out-of-range addresses are dropped.
            if (cfg_we && ap_idle_q && (32'(cfg_addr) < pTAP_NUM))
                tap_q[cfg_addr] <= cfg_wdata;

            case (state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        mode_q    <= cfg_mode;
                        shift_q   <= cfg_shift;
                        len_q     <= data_length;
                        idx_q     <= '0;
                        wptr_q    <= '0;
                        cnt_q     <= '0;
                        ap_idle_q <= 1'b0;
                        state_q   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    hist_q[idx_q] <= '0;
                    if (idx_q == LAST_IDX) begin
                        idx_q <= '0;
                        if (len_q == 16'd0) begin
                            ap_done_q <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            ss_tready_q <= 1'b1;
                            state_q     <= S_WAIT_IN;
                        end
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_WAIT_IN: begin
                    if (ss_tvalid) begin
                        hist_q[wptr_q] <= ss_tdata;
                        rptr_q         <= wptr_q;
                        wptr_q         <= wptr_d;
                        cnt_q          <= cnt_q + 16'd1;
                        last_q         <= last_d;
                        acc_q          <= '0;
                        idx_q          <= '0;
                        ss_tready_q    <= 1'b0;
                        if (mode_q) begin
                            sm_tvalid_q <= 1'b1;
                            sm_tdata_q  <= ss_tdata;
                            sm_tlast_q  <= last_d;
                            state_q     <= S_OUT;
                        end else begin
                            state_q <= S_MAC;
                        end
                    end
                end
                S_MAC: begin
                    // The final product is folded straight into the output register.
                    acc_q  <= acc_d;
                    rptr_q <= rptr_d;
                    if (idx_q == LAST_IDX) begin
                        sm_tvalid_q <= 1'b1;
                        sm_tdata_q  <= shifted[pDATA_WIDTH-1:0];
                        sm_tlast_q  <= last_q;
                        state_q     <= S_OUT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_OUT: begin
                    if (sm_tready) begin
                        sm_tvalid_q <= 1'b0;
                        sm_tlast_q  <= 1'b0;
                        if (last_q) begin
                            ap_done_q <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            ss_tready_q <= 1'b1;
                            state_q     <= S_WAIT_IN;
                        end
                    end
                end
                S_DONE: begin
                    ap_done_q <= 1'b0;
                    ap_idle_q <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ap_idle   = ap_idle_q;
    assign ap_done   = ap_done_q;
    assign ss_tready = ss_tready_q;
    assign sm_tvalid = sm_tvalid_q;
    assign sm_tdata  = sm_tdata_q;
    assign sm_tlast  = sm_tlast_q;

endmodule

// File: tb/tb_fir_stream_engine.sv
// Purpose : directed self-checking bench for fir_stream_engine (default parameters).
// Latency : measured in cycles; the handshake cycle is cycle 0.
// Backpressure: the output side is stalled on demand to exercise the hold behaviour.
module tb_fir_stream_engine;

    logic        clk = 1'b0;
    logic        axis_rst;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_mode;
    logic [4:0]  cfg_shift;
    logic        ap_start;
    logic [15:0] data_length;
    logic        ap_idle, ap_done;
    logic        ss_tvalid, ss_tready, ss_tlast;
    logic [31:0] ss_tdata;
    logic        sm_tvalid, sm_tready, sm_tlast;
    logic [31:0] sm_tdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    fir_stream_engine #(.pDATA_WIDTH(32), .pTAP_NUM(11), .pTAP_AW(5)) dut (
        .axis_clk(clk), .axis_rst(axis_rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_mode(cfg_mode), .cfg_shift(cfg_shift),
        .ap_start(ap_start), .data_length(data_length),
        .ap_idle(ap_idle), .ap_done(ap_done),
        .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
        .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $error("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_tap(input int addr, input logic [31:0] val);
        cfg_we = 1'b1; cfg_addr = 5'(addr); cfg_wdata = val;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic start_run(input logic mode, input logic [4:0] sh, input logic [15:0] len);
        cfg_mode = mode; cfg_shift = sh; data_length = len; ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        // Scramble the config inputs to prove they were captured at start.
        cfg_mode = ~mode; cfg_shift = sh + 5'd7; data_length = 16'hFFFF;
    endtask

    task automatic send(input logic [31:0] d, input logic l, output int h);
        int n = 0;
        ss_tvalid = 1'b1; ss_tdata = d; ss_tlast = l;
        while (!ss_tready && n < 200) begin tick(); n++; end
        check("ss_tready_timeout", {31'b0, ss_tready}, 32'd1);
        tick();
        h = cyc;
        ss_tvalid = 1'b0; ss_tlast = 1'b0; ss_tdata = 32'hDEAD_BEEF;
    endtask

    task automatic recv(input string tag, input logic [31:0] exp_d, input logic exp_l,
                        input int h, input int exp_lat, input int hold);
        int n = 0;
        while (!sm_tvalid && n < 200) begin tick(); n++; end
        check({tag, "_valid"}, {31'b0, sm_tvalid}, 32'd1);
        if (!sm_tvalid) return;
        check({tag, "_latency"}, 32'(cyc - h + 1), 32'(exp_lat));
        check({tag, "_data"}, sm_tdata, exp_d);
        check({tag, "_last"}, {31'b0, sm_tlast}, {31'b0, exp_l});
        for (int k = 0; k < hold; k++) begin
            tick();
            check({tag, "_hold_valid"}, {31'b0, sm_tvalid}, 32'd1);
            check({tag, "_hold_data"}, sm_tdata, exp_d);
            check({tag, "_hold_ready"}, {31'b0, ss_tready}, 32'd0);
        end
        sm_tready = 1'b1;
        tick();
        sm_tready = 1'b0;
    endtask

    task automatic expect_done_pulse(input string tag);
        check({tag, "_done_hi"}, {31'b0, ap_done}, 32'd1);
        tick();
        check({tag, "_done_lo"}, {31'b0, ap_done}, 32'd0);
        check({tag, "_idle"}, {31'b0, ap_idle}, 32'd1);
    endtask

    initial begin
        int h;
        int n;
        int seen_valid;
        logic [31:0] exp_v;
        logic [31:0] byp [4];

        axis_rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        cfg_mode = 1'b0; cfg_shift = '0; ap_start = 1'b0; data_length = '0;
        ss_tvalid = 1'b0; ss_tdata = '0; ss_tlast = 1'b0; sm_tready = 1'b0;
        tick(); tick();
        axis_rst = 1'b0;

        // Reset state
        check("rst_idle", {31'b0, ap_idle}, 32'd1);
        check("rst_done", {31'b0, ap_done}, 32'd0);
        check("rst_ss_tready", {31'b0, ss_tready}, 32'd0);
        check("rst_sm_tvalid", {31'b0, sm_tvalid}, 32'd0);
        check("rst_sm_tlast", {31'b0, sm_tlast}, 32'd0);
        check("rst_sm_tdata", sm_tdata, 32'd0);

        // Impulse response with taps 1..11; backpressure on the 5th output
        for (int i = 0; i < 11; i++) write_tap(i, 32'(i + 1));
        write_tap(11, 32'd99);
        start_run(1'b0, 5'd0, 16'd11);
        for (int k = 0; k < 11; k++) begin
            send((k == 0) ? 32'd1 : 32'd0, 1'b0, h);
            recv($sformatf("imp%0d", k), 32'(k + 1), (k == 10), h, 12, (k == 4) ? 5 : 0);
        end
        expect_done_pulse("imp");

        // Wrap-around: taps all 1, inputs 1..20, output = sum of last 11 inputs
        for (int i = 0; i < 11; i++) write_tap(i, 32'd1);
        start_run(1'b0, 5'd0, 16'd20);
        for (int k = 1; k <= 20; k++) begin
            exp_v = (k <= 11) ? 32'(k * (k + 1) / 2) : 32'(11 * k - 55);
            send(32'(k), 1'b0, h);
            recv($sformatf("wrap%0d", k), exp_v, (k == 20), h, 12, 0);
        end
        expect_done_pulse("wrap");

        // Bypass with early tlast on the 4th sample
        byp[0] = 32'h0000_00A5; byp[1] = 32'hFFFF_FFFD; byp[2] = 32'd7; byp[3] = 32'd100;
        start_run(1'b1, 5'd3, 16'd10);
        for (int k = 0; k < 4; k++) begin
            send(byp[k], (k == 3), h);
            recv($sformatf("byp%0d", k), byp[k], (k == 3), h, 1, 0);
        end
        expect_done_pulse("byp");

        // Signed tap with arithmetic shift: -4 * 8 = -32, >>> 2 = -8
        write_tap(0, 32'hFFFF_FFFC);
        for (int i = 1; i < 11; i++) write_tap(i, 32'd0);
        start_run(1'b0, 5'd2, 16'd1);
        send(32'd8, 1'b0, h);
        recv("shift", 32'hFFFF_FFF8, 1'b1, h, 12, 0);
        expect_done_pulse("shift");

        // Zero-length run: done without any output
        start_run(1'b0, 5'd0, 16'd0);
        n = 0; seen_valid = 0;
        while (!ap_done && n < 100) begin
            if (sm_tvalid || ss_tready) seen_valid++;
            tick(); n++;
        end
        check("len0_no_stream", 32'(seen_valid), 32'd0);
        expect_done_pulse("len0");

        // Reset in the middle of a MAC sequence
        for (int i = 0; i < 11; i++) write_tap(i, 32'd1);
        start_run(1'b0, 5'd0, 16'd3);
        send(32'd1000, 1'b0, h);
        tick(); tick(); tick();
        axis_rst = 1'b1;
        tick();
        axis_rst = 1'b0;
        check("midrst_idle", {31'b0, ap_idle}, 32'd1);
        check("midrst_sm_tvalid", {31'b0, sm_tvalid}, 32'd0);
        check("midrst_ss_tready", {31'b0, ss_tready}, 32'd0);
        check("midrst_sm_tdata", sm_tdata, 32'd0);

        // New run after reset; a tap write while busy must be ignored
        write_tap(0, 32'd1);
        write_tap(1, 32'd2);
        start_run(1'b0, 5'd0, 16'd2);
        write_tap(0, 32'd50);
        send(32'd3, 1'b0, h);
        recv("post0", 32'd3, 1'b0, h, 12, 0);
        send(32'd5, 1'b0, h);
        recv("post1", 32'd11, 1'b1, h, 12, 0);
        expect_done_pulse("post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
